// File: rtl/aes_stream_arbiter_if.sv
// Requester, cipher and result signals of the AES stream arbiter, bundled with
// the arbiter (slave) and environment (master) views.
interface aes_stream_arbiter_if;
  logic [1:0] req_i;
  logic [7:0] key0_i;
  logic [7:0] key1_i;
  logic [7:0] data0_i;
  logic [7:0] data1_i;
  logic [1:0] valid_i;
  logic [1:0] last_i;
  logic [1:0] ready_o;

  logic       cip_new_message;
  logic [7:0] cip_key;
  logic [7:0] cip_data_in;
  logic       cip_valid_in;
  logic [7:0] cip_data_out;
  logic       cip_valid_out;

  logic [7:0] out_data;
  logic [1:0] out_valid;
  logic [1:0] grant_o;
  logic       err_o;

  modport slave (
    input  req_i, key0_i, key1_i, data0_i, data1_i, valid_i, last_i,
    input  cip_data_out, cip_valid_out,
    output ready_o, cip_new_message, cip_key, cip_data_in, cip_valid_in,
    output out_data, out_valid, grant_o, err_o
  );

  modport master (
    output req_i, key0_i, key1_i, data0_i, data1_i, valid_i, last_i,
    output cip_data_out, cip_valid_out,
    input  ready_o, cip_new_message, cip_key, cip_data_in, cip_valid_in,
    input  out_data, out_valid, grant_o, err_o
  );
endinterface

// File: rtl/aes_stream_arbiter.sv
// Two-requester arbiter feeding a shared byte-stream cipher and routing results back.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (requester 0).
module aes_stream_arbiter #(
  parameter int MAX_OUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  aes_stream_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_OUT_C = 8'(MAX_OUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic       owner_reg, owner_next;
  logic [1:0] grant_reg, grant_next;
  logic [7:0] key_reg, key_next;
  logic [7:0] outstanding_reg, outstanding_next;
  logic       err_reg, err_next;

  logic       winner;
  logic       room;
  logic       accept;
  logic       owner_last;
  logic [1:0] ready_vec;
  logic [1:0] out_valid_vec;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_ptr_reg names the requester that wins a tie; the previous owner loses it.
  logic rr_ptr_reg, rr_ptr_next;

  always_comb begin
    if (bus.req_i == 2'b11) begin
      winner = rr_ptr_reg;
    end else begin
      winner = ~bus.req_i[0];
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (state_reg == IDLE && (|bus.req_i)) begin
      rr_ptr_next = ~winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`else
  always_comb begin
    winner = ~bus.req_i[0];
  end
`endif

  assign room       = (outstanding_reg < MAX_OUT_C);
  assign owner_last = bus.last_i[owner_reg];

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign ready_vec[gi]     = (state_reg == STREAM) && (owner_reg == 1'(gi)) && room;
    assign out_valid_vec[gi] = (state_reg != IDLE) && (owner_reg == 1'(gi)) && bus.cip_valid_out;
  end

  assign accept = |(ready_vec & bus.valid_i);

  // Next-state logic; ownership changes only at IDLE arbitration and after drain.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    grant_next = grant_reg;
    key_next   = key_reg;
    case (state_reg)
      IDLE: begin
        if (|bus.req_i) begin
          owner_next = winner;
          grant_next = winner ? 2'b10 : 2'b01;
          key_next   = winner ? bus.key1_i : bus.key0_i;
          state_next = START;
        end
      end
      START: begin
        state_next = STREAM;
      end
      STREAM: begin
        if (accept && owner_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_reg == 8'd0) begin
          grant_next = 2'b00;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Simultaneous issue and return cancel; a return with nothing outstanding is an error.
  always_comb begin
    outstanding_next = outstanding_reg;
    err_next         = err_reg;
    if (accept && !bus.cip_valid_out) begin
      outstanding_next = outstanding_reg + 8'd1;
    end else if (!accept && bus.cip_valid_out) begin
      if (outstanding_reg == 8'd0) begin
        err_next = 1'b1;
      end else begin
        outstanding_next = outstanding_reg - 8'd1;
      end
    end
    if (state_reg == IDLE && bus.cip_valid_out) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg       <= 1'b0;
      grant_reg       <= 2'b00;
      key_reg         <= 8'd0;
      outstanding_reg <= 8'd0;
      err_reg         <= 1'b0;
    end else begin
      owner_reg       <= owner_next;
      grant_reg       <= grant_next;
      key_reg         <= key_next;
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

  assign bus.ready_o         = ready_vec;
  assign bus.cip_new_message = (state_reg == START);
  assign bus.cip_key         = key_reg;
  assign bus.cip_valid_in    = accept;
  assign bus.cip_data_in     = owner_reg ? bus.data1_i : bus.data0_i;
  assign bus.out_data        = bus.cip_data_out;
  assign bus.out_valid       = out_valid_vec;
  assign bus.grant_o         = grant_reg;
  assign bus.err_o           = err_reg;

endmodule

// File: tb/tb_aes_stream_arbiter.sv
// Directed bench for aes_stream_arbiter with a fixed-latency XOR cipher model.
module tb_aes_stream_arbiter;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_stream_arbiter_if bus();

  aes_stream_arbiter #(.MAX_OUT(MAXO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Cipher model: byte XOR 5A returned lat edges after issue.
  int         lat = 4;
  logic [15:0] pipe_v = '0;
  logic [7:0]  pipe_d [16];
  always @(posedge clk) begin
    pipe_v <= {pipe_v[14:0], bus.cip_valid_in};
    pipe_d[0] <= bus.cip_data_in ^ 8'h5A;
    for (int k = 1; k < 16; k++) pipe_d[k] <= pipe_d[k-1];
  end
  assign bus.cip_valid_out = pipe_v[lat-1];
  assign bus.cip_data_out  = pipe_d[lat-1];

  int checks = 0;
  int failures = 0;
  int stalls = 0;

  // Observation logs and an independent outstanding-byte count.
  int         nm_cnt = 0;
  logic [7:0] nm_key = '0;
  logic [1:0] grant_log[$];
  logic [7:0] din_log[$];
  logic [1:0] ov_log[$];
  logic [7:0] od_log[$];
  int         bad_start = 0;
  int         both_at3 = 0;
  int         out_cur = 0;
  int         mx = 0;
  logic       inc_pend = 1'b0;
  logic       dec_pend = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cip_new_message) begin
        nm_cnt <= nm_cnt + 1;
        nm_key <= bus.cip_key;
        grant_log.push_back(bus.grant_o);
        if (bus.ready_o != 2'b00) bad_start <= bad_start + 1;
      end
      if (bus.cip_valid_in) din_log.push_back(bus.cip_data_in);
      if (bus.out_valid != 2'b00) begin
        ov_log.push_back(bus.out_valid);
        od_log.push_back(bus.out_data);
      end
      if (bus.cip_valid_in && bus.cip_valid_out && out_cur == 3) both_at3 <= both_at3 + 1;
    end
    inc_pend <= bus.cip_valid_in;
    dec_pend <= bus.cip_valid_out;
  end

  always @(posedge clk) begin
    if (reset) out_cur <= 0;
    else if (inc_pend && !dec_pend) out_cur <= out_cur + 1;
    else if (dec_pend && !inc_pend && out_cur > 0) out_cur <= out_cur - 1;
    if (out_cur > mx) mx <= out_cur;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_byte(input int r, input logic [7:0] d, input logic l, input logic v);
    if (r == 0) bus.data0_i = d; else bus.data1_i = d;
    bus.last_i[r]  = l;
    bus.valid_i[r] = v;
  endtask

  task automatic set_lat(input int l);
    repeat (17) @(posedge clk);
    #1;
    lat = l;
  endtask

  task automatic wait_idle(input int lim);
    int g = 0;
    while (bus.grant_o !== 2'b00 && g < lim) begin
      @(negedge clk);
      g++;
    end
    chk("idle_timeout", 32'(g < lim), 32'd1);
  endtask

  task automatic wait_stream(input int r);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(bus.grant_o[r] === 1'b1 && bus.cip_new_message === 1'b0) && g < 100);
    chk("stream_timeout", 32'(g < 100), 32'd1);
  endtask

  // Sends one message, checking ready_o against the bench outstanding count every cycle.
  task automatic send_msg(input int r, input logic [7:0] key, input int n, input logic [7:0] base);
    int   i = 0;
    int   g = 0;
    logic acc;
    logic exp_rdy;
    bus.req_i[r] = 1'b1;
    if (r == 0) bus.key0_i = key; else bus.key1_i = key;
    while (bus.grant_o[r] === 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    drive_byte(r, base, n == 1, 1'b1);
    while (i < n && g < 400) begin
      @(negedge clk);
      exp_rdy = bus.grant_o[r] && !bus.cip_new_message && (out_cur < MAXO);
      chk($sformatf("ready%0d", r), 32'(bus.ready_o[r]), 32'(exp_rdy));
      if (bus.grant_o[r] && !bus.cip_new_message && !bus.ready_o[r]) stalls++;
      acc = bus.ready_o[r];
      @(posedge clk);
      #1;
      g++;
      if (acc) begin
        i++;
        if (i < n) drive_byte(r, base + 8'(i), i == n - 1, 1'b1);
        else       drive_byte(r, 8'h00, 1'b0, 1'b0);
      end
    end
    bus.req_i[r] = 1'b0;
    chk("send_timeout", 32'(g < 400), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0, g0, s0, b0;
    bus.req_i = 2'b00; bus.valid_i = 2'b00; bus.last_i = 2'b00;
    bus.key0_i = 8'h00; bus.key1_i = 8'h00; bus.data0_i = 8'h00; bus.data1_i = 8'h00;

    // Reset state
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_grant", 32'(bus.grant_o), 32'h0);
    chk("rst_ready", 32'(bus.ready_o), 32'h0);
    chk("rst_newmsg", 32'(bus.cip_new_message), 32'h0);
    chk("rst_vin", 32'(bus.cip_valid_in), 32'h0);
    chk("rst_key", 32'(bus.cip_key), 32'h0);
    chk("rst_outv", 32'(bus.out_valid), 32'h0);
    chk("rst_err", 32'(bus.err_o), 32'h0);

    // Basic 3-byte message, latency 4
    send_msg(0, 8'h11, 3, 8'h00);
    chk("t1_grant_held", 32'(bus.grant_o), 32'h1);
    wait_idle(50);
    chk("t1_nm_cnt", 32'(nm_cnt), 32'd1);
    chk("t1_key", 32'(nm_key), 32'h11);
    chk("t1_grant_log", 32'(grant_log[0]), 32'h1);
    chk("t1_din_n", 32'(din_log.size()), 32'd3);
    chk("t1_ov_n", 32'(ov_log.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t1_din%0d", k), 32'(din_log[k]), 32'(k));
      chk($sformatf("t1_ov%0d", k), 32'(ov_log[k]), 32'h1);
      chk($sformatf("t1_od%0d", k), 32'(od_log[k]), 32'(8'(k) ^ 8'h5A));
    end
    chk("t1_start_ready", 32'(bad_start), 32'd0);
    chk("t1_err", 32'(bus.err_o), 32'h0);

    // Bubble in the middle of a message; key change after grant is ignored
    d0 = din_log.size();
    bus.req_i[0] = 1'b1;
    bus.key0_i = 8'h22;
    wait_stream(0);
    bus.key0_i = 8'hEE;
    @(posedge clk); #1 drive_byte(0, 8'hA0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_vin0", 32'(bus.cip_valid_in), 32'h1);
    chk("t2_din0", 32'(bus.cip_data_in), 32'hA0);
    @(posedge clk); #1 drive_byte(0, 8'hA0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_vin1", 32'(bus.cip_valid_in), 32'h0);
    @(posedge clk); #1 drive_byte(0, 8'hA1, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_vin2", 32'(bus.cip_valid_in), 32'h1);
    chk("t2_din2", 32'(bus.cip_data_in), 32'hA1);
    chk("t2_key", 32'(bus.cip_key), 32'h22);
    @(posedge clk); #1 drive_byte(0, 8'h00, 1'b0, 1'b0);
    bus.req_i[0] = 1'b0;
    wait_idle(50);
    chk("t2_din_n", 32'(din_log.size() - d0), 32'd2);
    chk("t2_din_a", 32'(din_log[d0]), 32'hA0);
    chk("t2_din_b", 32'(din_log[d0+1]), 32'hA1);

    // Back-pressure: 8 bytes at latency 10 against MAX_OUT=4
    set_lat(10);
    d0 = din_log.size();
    o0 = ov_log.size();
    s0 = stalls;
    send_msg(1, 8'h33, 8, 8'h10);
    wait_idle(100);
    chk("t3_stalled", 32'(stalls > s0), 32'd1);
    chk("t3_max_out", 32'(mx), 32'd4);
    chk("t3_grant_log", 32'(grant_log[grant_log.size()-1]), 32'h2);
    chk("t3_ov_n", 32'(ov_log.size() - o0), 32'd8);
    chk("t3_ov_owner", 32'(ov_log[o0]), 32'h2);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_din%0d", k), 32'(din_log[d0+k]), 32'(8'h10 + 8'(k)));
    end

    // Issue and return in the same cycle at outstanding 3: ready never drops
    set_lat(3);
    s0 = stalls;
    b0 = both_at3;
    send_msg(0, 8'h44, 6, 8'h60);
    wait_idle(50);
    chk("t4_no_stall", 32'(stalls - s0), 32'd0);
    chk("t4_both_seen", 32'(both_at3 > b0), 32'd1);
    chk("t4_err", 32'(bus.err_o), 32'h0);

    // Reset with two bytes in flight; their late returns must flag err_o only
    set_lat(10);
    bus.req_i[0] = 1'b1;
    bus.key0_i = 8'h77;
    wait_stream(0);
    drive_byte(0, 8'hB0, 1'b0, 1'b1);
    @(posedge clk); #1 drive_byte(0, 8'hB1, 1'b0, 1'b1);
    @(posedge clk); #1 drive_byte(0, 8'h00, 1'b0, 1'b0);
    bus.req_i[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("t5_grant", 32'(bus.grant_o), 32'h0);
    chk("t5_err_clr", 32'(bus.err_o), 32'h0);
    chk("t5_ready", 32'(bus.ready_o), 32'h0);
    o0 = ov_log.size();
    repeat (14) @(posedge clk);
    #1;
    chk("t5_err_set", 32'(bus.err_o), 32'h1);
    chk("t5_no_outv", 32'(ov_log.size() - o0), 32'd0);

    // Both requesters, two messages each
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    set_lat(4);
    g0 = grant_log.size();
    fork
      begin
        send_msg(0, 8'h44, 2, 8'h80);
        send_msg(0, 8'h44, 2, 8'h82);
      end
      begin
        send_msg(1, 8'h55, 2, 8'h90);
        send_msg(1, 8'h55, 2, 8'h92);
      end
    join
    wait_idle(50);
    chk("t6_grant_n", 32'(grant_log.size() - g0), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t6_g0", 32'(grant_log[g0]),   32'h1);
    chk("t6_g1", 32'(grant_log[g0+1]), 32'h2);
    chk("t6_g2", 32'(grant_log[g0+2]), 32'h1);
    chk("t6_g3", 32'(grant_log[g0+3]), 32'h2);
`else
    chk("t6_g0", 32'(grant_log[g0]),   32'h1);
    chk("t6_g1", 32'(grant_log[g0+1]), 32'h1);
    chk("t6_g2", 32'(grant_log[g0+2]), 32'h2);
    chk("t6_g3", 32'(grant_log[g0+3]), 32'h2);
`endif
    chk("t6_err", 32'(bus.err_o), 32'h0);
    chk("t6_start_ready", 32'(bad_start), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_stream_arbiter.md
AES_STREAM_ARBITER -- requirements
Module: aes_stream_arbiter

Interface
REQ-001 Parameter MAX_OUT, default 16: maximum bytes issued to the cipher and not yet returned; range 2..255.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_i[1:0]  in  2  per-requester message request; held until its last byte is accepted.
REQ-005 key0_i, key1_i  in  8 each  per-requester key; sampled at grant.
REQ-006 data0_i, data1_i  in  8 each  per-requester plaintext byte.
REQ-007 valid_i[1:0]  in  2  per-requester byte valid.
REQ-008 last_i[1:0]  in  2  marks the final byte of a message; qualified by valid_i.
REQ-009 ready_o[1:0]  out  2  byte accepted when valid_i and ready_o are high on the same edge.
REQ-010 cip_new_message  out  1  one-cycle start pulse to the cipher.
REQ-011 cip_key  out  8  key to the cipher; stable from the pulse until the message is drained.
REQ-012 cip_data_in / cip_valid_in  out  8 / 1  byte stream to the cipher.
REQ-013 cip_data_out / cip_valid_out  in  8 / 1  cipher result stream.
REQ-014 out_data  out  8  ciphertext byte, copy of cip_data_out.
REQ-015 out_valid[1:0]  out  2  one-hot; high only for the owner of the returned byte.
REQ-016 grant_o[1:0]  out  2  one-hot current owner; zero in IDLE.
REQ-017 err_o  out  1  sticky; set when a cipher output arrives with zero outstanding bytes.

Function
REQ-018 States: IDLE, START, STREAM, DRAIN.
REQ-019 IDLE: if any req_i is high, latch the winner and its key, then go to START; otherwise stay.
REQ-020 START, one cycle: cip_new_message=1, cip_key=latched key, ready_o=0, then go to STREAM.
REQ-021 STREAM: ready_o[owner]=1 when outstanding<MAX_OUT; the other ready_o bit is 0.
REQ-022 Each accepted byte drives cip_data_in/cip_valid_in combinationally in the same cycle, so latency is zero.
REQ-023 When valid_i[owner] is low, cip_valid_in is 0 (bubble); cip_data_in is don't-care.
REQ-024 An accepted byte with last_i[owner] high moves the FSM to DRAIN.
REQ-025 DRAIN: ready_o=0; when outstanding==0, go to IDLE and clear grant_o.
REQ-026 The outstanding counter increments on cip_valid_in and decrements on cip_valid_out, and is unchanged when both occur.
REQ-027 Outstanding never wraps; a decrement at zero is dropped and sets err_o.
REQ-028 out_valid[owner]=cip_valid_out, combinational, in every state except IDLE.
REQ-029 cip_valid_out in IDLE sets err_o, and out_valid stays 0.
REQ-030 A request that drops before its last byte is ignored; ownership ends only on last or reset.
REQ-031 The owner's key0_i/key1_i may change after grant without effect.

Reset
REQ-032 Reset forces: IDLE, outstanding=0, grant_o=0, ready_o=0, cip_new_message=0, cip_valid_in=0, cip_key=0, out_valid=0, err_o=0, RR pointer=0.
REQ-033 Reset mid-message abandons in-flight bytes; outputs returned after reset are treated per REQ-029.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: the last owner gets lowest priority at the next IDLE arbitration; the pointer updates on the transition to START.
REQ-035 ARB_ROUND_ROBIN_EN undefined: fixed priority, with requester 0 always winning ties.

Verification
REQ-036 Bench: req_i=01, key0=11, 3 bytes 00,01,02 with last on 02, cipher model latency 4 -> one cip_new_message with cip_key=11; cip_data_in 00,01,02; out_valid=01 three times; grant_o back to 00 after the last return.
REQ-037 Bench: req_i=11 held for two messages each, RR enabled -> grants alternate 01,10,01,10; RR disabled -> 01,01 before 10.
REQ-038 Bench: MAX_OUT=4, cipher latency 10, 8-byte message -> ready_o drops after 4 bytes and resumes as returns arrive; outstanding never exceeds 4.
REQ-039 Bench: valid0 toggles 1,0,1 in STREAM -> cip_valid_in follows 1,0,1 with no duplicated byte.
REQ-040 Bench: reset asserted with 2 bytes outstanding, then 2 cipher outputs -> out_valid stays 00 and err_o=1.
REQ-041 Bench: one cycle with both issue and return at outstanding=3 -> outstanding remains 3.
